// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the instruction-memory program loader.
// The FSM state encoding and the image base address live here so every loader file agrees on them.
package loader_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RECV  = 2'd1,
        WRITE = 2'd2,
        DONE  = 2'd3
    } loader_state_t;

    localparam int          BYTES_PER_WORD = 4;
    localparam logic [31:0] IMEM_BASE      = 32'h0;

endpackage

// File: rtl/imem_loader_byte_packer.sv
// Packs a byte stream little-endian into 32-bit words: a wrapping byte counter plus a shift register.
// After four pushes, byte n of the word sits in bits [8n+7:8n].
module byte_packer
    import loader_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        clr,
    input  logic        push,
    input  logic [7:0]  byte_in,
    output logic [31:0] word_out,
    output logic        last
);

    localparam int CW = $clog2(BYTES_PER_WORD);

    logic [CW-1:0] byteCnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            byteCnt  <= '0;
            word_out <= '0;
        end else if (clr) begin
            byteCnt  <= '0;
            word_out <= '0;
        end else if (push) begin
            byteCnt  <= byteCnt + 1'b1;
            word_out <= {byte_in, word_out[31:8]};
        end
    end

    // High while the next accepted byte completes the word.
    assign last = (byteCnt == CW'(BYTES_PER_WORD - 1));

endmodule

// File: rtl/imem_loader.sv
// Write side of instruction memory: streams bytes into words, writes them in order,
// and holds the core in reset until the whole image has been written.
//
//   state | meaning
//   IDLE  | no load in progress, core held in reset
//   RECV  | accepting bytes of the current word
//   WRITE | one-cycle memory write of the packed word
//   DONE  | image complete, core released
module imem_loader
    import loader_pkg::*;
#(
    parameter int WORDS = 1024,
    parameter int AW    = $clog2(WORDS)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [AW:0]   word_count,
    input  logic          in_valid,
    input  logic [7:0]    in_data,
    output logic          in_ready,
    output logic          mem_we,
    output logic [31:0]   mem_addr,
    output logic [31:0]   mem_wdata,
    output logic          core_rst,
    output logic          busy,
    output logic          done,
    output logic          err,
    output logic [31:0]   checksum
);

    loader_state_t stateQ, stateD;

    logic [AW:0]  wordCnt;
    logic [AW:0]  wordIdx;
    logic [AW:0]  idxNext;
    logic [31:0]  memAddrQ;
    logic [31:0]  memWdataQ;
    logic [31:0]  curAddr;
    logic [31:0]  packWord;
    logic         packLast;
    logic         accept;
    logic         startLegal;
    logic         canStart;
    logic         loadStart;

    byte_packer uPacker (
        .clk      (clk),
        .rst      (rst),
        .clr      (loadStart),
        .push     (accept),
        .byte_in  (in_data),
        .word_out (packWord),
        .last     (packLast)
    );

    always_comb begin
        stateD     = stateQ;
        startLegal = (word_count != '0) && (word_count <= (AW+1)'(WORDS));
        canStart   = (stateQ == IDLE) || (stateQ == DONE);
        loadStart  = canStart && start && startLegal;
        accept     = (stateQ == RECV) && in_valid;
        idxNext    = wordIdx + 1'b1;
        curAddr    = IMEM_BASE + 32'({wordIdx, 2'b00});

        case (stateQ)
            IDLE:    if (loadStart) stateD = RECV;
            RECV:    if (accept && packLast) stateD = WRITE;
            WRITE:   stateD = (idxNext == wordCnt) ? DONE : RECV;
            DONE:    if (start) stateD = startLegal ? RECV : IDLE;
            default: stateD = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stateQ    <= IDLE;
            wordCnt   <= '0;
            wordIdx   <= '0;
            memAddrQ  <= '0;
            memWdataQ <= '0;
            checksum  <= '0;
            err       <= 1'b0;
        end else begin
            stateQ <= stateD;
            if (loadStart) begin
                wordCnt  <= word_count;
                wordIdx  <= '0;
                checksum <= '0;
                err      <= 1'b0;
            end else if (canStart && start) begin
                err <= 1'b1;
            end
            if (stateQ == WRITE) begin
                memAddrQ  <= curAddr;
                memWdataQ <= packWord;
                checksum  <= checksum ^ packWord;
                wordIdx   <= idxNext;
            end
        end
    end

    // Address/data show the live word during WRITE and hold the last written values otherwise.
    assign mem_we    = (stateQ == WRITE);
    assign mem_addr  = (stateQ == WRITE) ? curAddr  : memAddrQ;
    assign mem_wdata = (stateQ == WRITE) ? packWord : memWdataQ;
    assign in_ready  = (stateQ == RECV);
    assign busy      = (stateQ == RECV) || (stateQ == WRITE);
    assign done      = (stateQ == DONE);
    assign core_rst  = (stateQ != DONE);

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: drives byte streams, queues the expected memory writes,
// and compares them as the loader produces mem_we cycles.
module tb_imem_loader;
    import loader_pkg::*;

    localparam int WORDS = 1024;
    localparam int AW    = 10;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [AW:0]   word_count;
    logic          in_valid;
    logic [7:0]    in_data;
    logic          in_ready;
    logic          mem_we;
    logic [31:0]   mem_addr;
    logic [31:0]   mem_wdata;
    logic          core_rst;
    logic          busy;
    logic          done;
    logic          err;
    logic [31:0]   checksum;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
    } wr_t;

    wr_t         sbQ[$];
    int          errors = 0;
    int          checks = 0;
    int          expIdx = 0;
    int          wrCount = 0;
    int          doneCnt;
    logic [31:0] expSum = '0;
    logic [31:0] lastAddr = '0;

    imem_loader #(.WORDS(WORDS), .AW(AW)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .word_count (word_count),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .in_ready   (in_ready),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .core_rst   (core_rst),
        .busy       (busy),
        .done       (done),
        .err        (err),
        .checksum   (checksum)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic monitor();
        wr_t e;
        forever begin
            @(negedge clk);
            if (mem_we === 1'b1) begin
                if (sbQ.size() == 0) begin
                    chk("unexpected_we", 32'(mem_addr), 32'hFFFF_FFFF);
                end else begin
                    e = sbQ.pop_front();
                    chk("wr_addr", mem_addr, e.addr);
                    chk("wr_data", mem_wdata, e.data);
                end
                wrCount++;
                lastAddr = mem_addr;
            end
        end
    endtask

    task automatic startLoad(input int n);
        @(negedge clk);
        start      = 1'b1;
        word_count = (AW+1)'(n);
        if (n >= 1 && n <= WORDS) begin
            expIdx  = 0;
            expSum  = '0;
            wrCount = 0;
        end
        @(negedge clk);
        start = 1'b0;
    endtask

    // Drives bytes from the current negedge; a byte counts as accepted when valid meets ready.
    task automatic feed(input int nBytes, input bit gaps, input bit fixed13);
        int          b = 0;
        int          cyc = 0;
        logic [31:0] w = '0;
        logic [7:0]  d;
        while (b < nBytes && cyc < nBytes * 4 + 20) begin
            in_valid = gaps ? (cyc % 2 == 0) : 1'b1;
            d        = fixed13 ? ((b == 0) ? 8'h13 : 8'h00) : 8'($urandom_range(0, 255));
            in_data  = d;
            if (in_valid && in_ready) begin
                w[8*(b%4) +: 8] = d;
                if (b % 4 == 3) begin
                    sbQ.push_back('{addr: IMEM_BASE + 32'(expIdx * 4), data: w});
                    expSum ^= w;
                    expIdx++;
                end
                b++;
            end
            @(negedge clk);
            cyc++;
        end
        in_valid = 1'b0;
        if (b < nBytes) chk("feed_timeout", 32'(b), 32'(nBytes));
    endtask

    task automatic waitDone(output int cnt);
        cnt = 1;
        while (done !== 1'b1 && cnt < 200) begin
            @(negedge clk);
            cnt++;
        end
        if (done !== 1'b1) chk("done_timeout", 32'(done), 32'h1);
    endtask

    task automatic checkResetOutputs(input string tag);
        chk({tag, "_core_rst"},  32'(core_rst),  32'h1);
        chk({tag, "_in_ready"},  32'(in_ready),  32'h0);
        chk({tag, "_mem_we"},    32'(mem_we),    32'h0);
        chk({tag, "_busy"},      32'(busy),      32'h0);
        chk({tag, "_done"},      32'(done),      32'h0);
        chk({tag, "_err"},       32'(err),       32'h0);
        chk({tag, "_mem_addr"},  mem_addr,       32'h0);
        chk({tag, "_mem_wdata"}, mem_wdata,      32'h0);
        chk({tag, "_checksum"},  checksum,       32'h0);
    endtask

    initial begin
        rst        = 1'b1;
        start      = 1'b0;
        word_count = '0;
        in_valid   = 1'b0;
        in_data    = 8'h00;
        fork
            monitor();
        join_none
        repeat (2) @(negedge clk);
        checkResetOutputs("rst");
        rst = 1'b0;

        // Single word, continuous valid: DONE in cycle k+6.
        startLoad(1);
        fork
            feed(4, 1'b0, 1'b1);
            waitDone(doneCnt);
        join
        chk("t1_done_cycle", 32'(doneCnt), 32'd6);
        chk("t1_core_rst",   32'(core_rst), 32'h0);
        chk("t1_checksum",   checksum, 32'h0000_0013);
        chk("t1_writes",     32'(wrCount), 32'd1);
        chk("t1_wdata_hold", mem_wdata, 32'h0000_0013);

        // Illegal counts: zero from DONE, then above depth from IDLE.
        startLoad(0);
        chk("ill0_err",      32'(err),      32'h1);
        chk("ill0_done",     32'(done),     32'h0);
        chk("ill0_core_rst", 32'(core_rst), 32'h1);
        startLoad(WORDS + 1);
        repeat (3) @(negedge clk);
        chk("ill1_err",      32'(err),      32'h1);
        chk("ill1_busy",     32'(busy),     32'h0);
        chk("ill1_in_ready", 32'(in_ready), 32'h0);
        chk("ill1_writes",   32'(wrCount),  32'd1);

        // Three words with valid toggling every other cycle.
        startLoad(3);
        chk("gap_err_clr",  32'(err),      32'h0);
        chk("gap_busy",     32'(busy),     32'h1);
        chk("gap_core_rst", 32'(core_rst), 32'h1);
        feed(12, 1'b1, 1'b0);
        waitDone(doneCnt);
        chk("gap_writes",   32'(wrCount), 32'd3);
        chk("gap_last",     lastAddr, 32'h8);
        chk("gap_checksum", checksum, expSum);

        // Restart from DONE: core reset reasserted, checksum restarted.
        startLoad(2);
        chk("rs_core_rst", 32'(core_rst), 32'h1);
        chk("rs_checksum", checksum, 32'h0);
        feed(8, 1'b0, 1'b0);
        waitDone(doneCnt);
        chk("rs_writes",   32'(wrCount), 32'd2);
        chk("rs_checksum_final", checksum, expSum);

        // Full depth.
        startLoad(WORDS);
        feed(WORDS * 4, 1'b0, 1'b0);
        waitDone(doneCnt);
        chk("full_writes",   32'(wrCount), 32'(WORDS));
        chk("full_last",     lastAddr, 32'hFFC);
        chk("full_hold",     mem_addr, 32'hFFC);
        chk("full_checksum", checksum, expSum);

        // Reset after two bytes of word 2.
        startLoad(3);
        feed(10, 1'b0, 1'b0);
        rst = 1'b1;
        #1;
        checkResetOutputs("mid");
        chk("mid_writes",  32'(wrCount), 32'd2);
        chk("mid_sb_empty", 32'(sbQ.size()), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        startLoad(1);
        feed(4, 1'b0, 1'b0);
        waitDone(doneCnt);
        chk("reload_writes", 32'(wrCount), 32'd1);
        chk("reload_addr",   lastAddr, 32'h0);
        chk("reload_checksum", checksum, expSum);
        chk("end_sb_empty",  32'(sbQ.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/imem_loader.md
# imem_loader

Program loader for the single-cycle RISC-V core: the write side of instruction memory, which the core's fetch path only reads. It accepts a byte stream over a valid/ready handshake, packs bytes little-endian into 32-bit instructions, and writes them to consecutive word addresses. It holds the core in reset until the programmed image is complete. It sits beside the core top level and drives the instruction memory write port and the core's `rst`.

## Interface
- `WORDS`, 1024: instruction memory depth in words.
- `AW`, 10: word-index width, `$clog2(WORDS)`.
- `clk`  in  1  system clock, rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `start`  in  1  single-cycle request to begin a load.
- `word_count`  in  AW+1  number of words to load; sampled when `start` is accepted.
- `in_valid`  in  1  `in_data` byte is valid.
- `in_data`  in  8  program byte.
- `in_ready`  out  1  loader accepts a byte this cycle.
- `mem_we`  out  1  instruction memory write strobe.
- `mem_addr`  out  32  byte address, word-aligned, equal to word index × 4.
- `mem_wdata`  out  32  packed instruction.
- `core_rst`  out  1  reset to the core; high until the load completes.
- `busy`  out  1  high in RECV or WRITE.
- `done`  out  1  high in DONE.
- `err`  out  1  sticky flag for an illegal `word_count`.
- `checksum`  out  32  running XOR of all words written in the current load.

## Operation
- FSM states: IDLE, RECV, WRITE, DONE.
- IDLE: `core_rst`=1, `in_ready`=0.
  - `start` with 1 ≤ `word_count` ≤ `WORDS`: latch the count, clear the word index, byte counter and checksum, then go to RECV.
  - `start` with `word_count`=0 or `word_count` > `WORDS`: set `err`, stay in IDLE.
  - A legal `start` clears `err`.
- RECV: `in_ready`=1.
  - A byte is accepted on `in_valid & in_ready`.
  - Byte n (n = 0..3) goes to bits [8n+7:8n] of the shift register.
  - The 2-bit byte counter wraps.
  - On acceptance of byte 3, go to WRITE.
  - If `in_valid` is low, stay in RECV with no change.
- WRITE: one cycle. `in_ready`=0, `mem_we`=1, `mem_addr`={word_idx, 2'b00} zero-extended, `mem_wdata` = packed word.
  - `checksum` ^= word, registered at the end of the cycle.
  - Increment the word index.
  - If the incremented index equals the count, go to DONE; otherwise go to RECV.
- DONE: `core_rst`=0, `done`=1, `in_ready`=0.
  - A legal `start` re-enters RECV and reasserts `core_rst` in the same cycle the state changes.
  - An illegal `start` sets `err` and goes to IDLE.
- `start` in RECV or WRITE is ignored.
- Word index arithmetic is AW+1 bits, so `word_count`=`WORDS` terminates without wrap.
- Outside WRITE, `mem_we`=0 and `mem_addr` and `mem_wdata` hold their last values.

## Timing
- Reset values:
  - state = IDLE.
  - `core_rst`=1.
  - `in_ready`, `mem_we`, `busy`, `done`, `err` = 0.
  - `mem_addr`, `mem_wdata`, `checksum` = 0.
- All outputs are registered or decoded from registered state only; there is no combinational path from `in_valid` to `in_ready`.
- `start` sampled at edge k puts the FSM in RECV from cycle k+1.
- With `in_valid` held high, N words complete as follows:
  - Word i is written in cycle k+5(i+1).
  - DONE is entered in cycle k+5N+1.
  - Throughput is 4 bytes per 5 cycles.
- A `rst` assertion mid-load returns immediately to the reset state.
  - The partial word is discarded and is never written.
  - Memory contents already written are unchanged.
- `core_rst` deasserts on the same edge that enters DONE, after the final `mem_we` cycle. The core's first fetch therefore sees a complete image.

## Structure
- Shared package `loader_pkg`:
  - state enum `loader_state_t`.
  - constant `BYTES_PER_WORD`=4.
  - reset-vector constant `IMEM_BASE`=32'h0, added to `mem_addr`.
- One sub-module, `byte_packer`: 2-bit counter plus a 32-bit shift register. Its ports are `clk`, `rst`, `clr`, `push`, `byte_in`, `word_out` and `last`.
- The FSM, index, checksum and output registers live in `imem_loader`.

## Test plan
- **Single-word load.** `word_count`=1, bytes 13,00,00,00 with continuous valid.
  - One `mem_we` at `mem_addr`=0 with data 32'h00000013.
  - `done` and `core_rst`=0 at cycle k+6.
  - `checksum`=32'h00000013.
- **Backpressure gaps.** 3 words with `in_valid` toggled every other cycle.
  - Writes to addresses 0, 4, 8 with correct little-endian words.
  - No write occurs without 4 accepted bytes.
- **Illegal count.** `start` with `word_count`=0, then 1025.
  - `err`=1, state stays IDLE, `core_rst`=1, no `mem_we`.
  - A following legal `start` clears `err`.
- **Full depth.** `word_count`=1024.
  - Last write at `mem_addr`=32'hFFC.
  - DONE entered with no wrap to address 0.
- **Reset mid-word.** Assert `rst` after 2 bytes of word 2.
  - All outputs return to their reset values.
  - Word 2 is never written.
  - Reload with `start` begins at address 0.
- **Restart from DONE.** Issue `start` in DONE with `word_count`=2.
  - `core_rst` returns to 1.
  - `checksum` is cleared and recomputed over the new words only.
